cla_8bit: RTL and testbench

Registered 8-bit two's-complement adder/subtractor built on a carry-lookahead carry network. Each clock it computes A+B or A−B, the carry-out and the signed-overflow flag, and registers all three results. It serves as the arithmetic leaf of the datapath, replacing a ripple adder where carry delay limits cycle time.

---
 rtl/cla_pkg.sv | 5 +
 rtl/cla_4bit.sv | 32 +++
 rtl/cla_8bit.sv | 69 ++++++
 tb/tb_cla_8bit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants for the carry-lookahead adder/subtractor.
package cla_pkg;
    localparam int CLA_W   = 8;
    localparam int CLA_GRP = 4;
endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead group: flat carry equations, group generate/propagate.
import cla_pkg::*;

module cla_4bit (
    input  logic [CLA_GRP-1:0] a,
    input  logic [CLA_GRP-1:0] b,
    input  logic               cin,
    output logic [CLA_GRP-1:0] s,
    output logic               G,
    output logic               P,
    output logic               c3
);
    logic [CLA_GRP-1:0] g;
    logic [CLA_GRP-1:0] p;
    logic               c1;
    logic               c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a two-level sum of products of g/p/cin; no ripple.
    assign c1 = g[0] | (p[0] & cin);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

    assign s = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/cla_8bit.sv
// Registered 8-bit add/subtract on a two-level carry-lookahead network,
// producing sum, raw carry-out and signed overflow.
import cla_pkg::*;

module cla_8bit (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CLA_W-1:0] A,
    input  logic [CLA_W-1:0] B,
    input  logic             Add_ctrl,
    output logic [CLA_W-1:0] SUM,
    output logic             C_out,
    output logic             v
);
    logic [CLA_W-1:0] bx;
    logic [CLA_W-1:0] sum_nxt;
    logic             c0;
    logic             c4;
    logic             c8;
    logic             c3_lo;
    logic             c7;
    logic             g_lo;
    logic             p_lo;
    logic             g_hi;
    logic             p_hi;

    // Subtraction is A + ~B + 1.
    assign bx = Add_ctrl ? B : ~B;
    assign c0 = ~Add_ctrl;

    assign c4 = g_lo | (p_lo & c0);
    assign c8 = g_hi | (p_hi & g_lo) | (p_hi & p_lo & c0);

    cla_4bit u_lo (
        .a   (A[CLA_GRP-1:0]),
        .b   (bx[CLA_GRP-1:0]),
        .cin (c0),
        .s   (sum_nxt[CLA_GRP-1:0]),
        .G   (g_lo),
        .P   (p_lo),
        .c3  (c3_lo)
    );

    cla_4bit u_hi (
        .a   (A[CLA_W-1:CLA_GRP]),
        .b   (bx[CLA_W-1:CLA_GRP]),
        .cin (c4),
        .s   (sum_nxt[CLA_W-1:CLA_GRP]),
        .G   (g_hi),
        .P   (p_hi),
        .c3  (c7)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            SUM   <= '0;
            C_out <= 1'b0;
            v     <= 1'b0;
        end else begin
            SUM   <= sum_nxt;
            C_out <= c8;
            v     <= c7 ^ c8;
        end
    end

    // Lower-group c3 is internal to that group; only the upper one feeds overflow.
    logic unused_c3_lo;
    assign unused_c3_lo = c3_lo;
endmodule

// File: tb/tb_cla_8bit.sv
// Scoreboard bench for cla_8bit: driver queues expected results per cycle,
// monitor pops and compares one cycle later.
module tb_cla_8bit;
    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic       Add_ctrl;
    logic [7:0] SUM;
    logic       C_out;
    logic       v;

    typedef struct {
        logic [7:0] sum;
        logic       c;
        logic       v;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   drive_done = 0;

    cla_8bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .Add_ctrl (Add_ctrl),
        .SUM      (SUM),
        .C_out    (C_out),
        .v        (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors: A, B, Add_ctrl, expected SUM, C_out, v.
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       add;
        logic [7:0] sum;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vecs[15] = '{
        '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0},
        '{8'h02, 8'h03, 1'b1, 8'h05, 1'b0, 1'b0},
        '{8'h7F, 8'h7F, 1'b1, 8'hFE, 1'b0, 1'b1},
        '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1},
        '{8'h81, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0},
        '{8'hFF, 8'hFF, 1'b1, 8'hFE, 1'b1, 1'b0},
        '{8'hFE, 8'hFD, 1'b1, 8'hFB, 1'b1, 1'b0},
        '{8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h02, 8'h03, 1'b0, 8'hFF, 1'b0, 1'b0},
        '{8'h7F, 8'h7F, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'hFE, 8'hFD, 1'b0, 8'h01, 1'b1, 1'b0},
        '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b1, 1'b1},
        '{8'h81, 8'h7F, 1'b0, 8'h02, 1'b1, 1'b1},
        '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0}
    };

    task automatic drive(input logic rst, input logic [7:0] a, input logic [7:0] b,
                         input logic add, input logic [7:0] es, input logic ec,
                         input logic ev, input int tag);
        exp_t e;
        @(negedge clk);
        rst_n    = rst;
        A        = a;
        B        = b;
        Add_ctrl = add;
        e.sum = es;
        e.c   = ec;
        e.v   = ev;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Independent reference: 9-bit sum and sign-rule overflow.
    task automatic drive_ref(input logic [7:0] a, input logic [7:0] b,
                             input logic add, input int tag);
        logic [7:0] bx;
        logic [8:0] r;
        logic       ov;
        bx = add ? b : ~b;
        r  = {1'b0, a} + {1'b0, bx} + {8'd0, ~add};
        ov = (a[7] == bx[7]) && (r[7] != a[7]);
        drive(1'b1, a, b, add, r[7:0], r[8], ov, tag);
    endtask

    initial begin
        rst_n = 1'b0; A = 8'h00; B = 8'h00; Add_ctrl = 1'b1;
        // Reset held with operands that would overflow.
        for (int i = 0; i < 3; i++)
            drive(1'b0, 8'h7F, 8'h01, 1'b1, 8'h00, 1'b0, 1'b0, 100 + i);
        drive(1'b1, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1, 103);
        for (int i = 0; i < 15; i++)
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].add,
                  vecs[i].sum, vecs[i].c, vecs[i].v, i);
        // Mid-stream reset discards the in-flight result.
        drive(1'b0, 8'h7F, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b0, 200);
        drive(1'b1, 8'h02, 8'h03, 1'b0, 8'hFF, 1'b0, 1'b0, 201);
        for (int i = 0; i < 10000; i++)
            drive_ref(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), 1000 + i);
        drive_done = 1;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (SUM !== e.sum || C_out !== e.c || v !== e.v) begin
                    failures++;
                    $display("FAIL vec%0d: got SUM=%h C_out=%b v=%b expected SUM=%h C_out=%b v=%b",
                             e.tag, SUM, C_out, v, e.sum, e.c, e.v);
                end
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        while (!drive_done && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (!drive_done || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: done=%0d pending=%0d expected done=1 pending=0",
                     drive_done, exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
